// File: rtl/vga_update_scheduler_if.sv
// Producer-side write request bus for the display update scheduler.
// Producers drive req/addr/data; the scheduler returns grant and ack.
interface vga_update_scheduler_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;

    modport master (
        output req,
        output wr_addr,
        output wr_data,
        input  gnt,
        input  ack
    );

    modport slave (
        input  req,
        input  wr_addr,
        input  wr_data,
        output gnt,
        output ack
    );
endinterface

// File: rtl/vga_update_scheduler.sv
// Round-robin display-register writer that only updates during vblank.
// Each write takes three clocks: grant/strobe, ack, then re-arbitrate.
module vga_update_scheduler #(
    parameter int NREQ   = 4,
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int VD     = 480,
    parameter int VT     = 525,
    parameter int MAX_WR = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [9:0]            pixelx,
    input  logic [9:0]            pixely,
    vga_update_scheduler_if.slave bus,
    output logic                  reg_we,
    output logic [AW-1:0]         reg_addr,
    output logic [DW-1:0]         reg_data,
    output logic                  vblank,
    output logic                  frame_start,
    output logic                  starved
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_WR + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WR);
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            reg_we_q, reg_we_d;
    logic [AW-1:0]   reg_addr_q, reg_addr_d;
    logic [DW-1:0]   reg_data_q, reg_data_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            vblank_q, vblank_d;
    logic            frame_start_q, frame_start_d;
    logic            starved_q, starved_d;

    logic [NREQ-1:0] hi_req;
    logic [LW-1:0]   win;
    logic            found;

    // Window flag, frame pulse and starvation pulse at window close.
    always_comb begin
        vblank_d      = (pixely >= 10'(VD)) && (pixely < 10'(VT - 1));
        frame_start_d = tick && (pixelx == 10'd0) && (pixely == 10'd0);
        starved_d     = vblank_q && !vblank_d && (|bus.req);
    end

    // Winner: lowest request above the last winner, else lowest overall.
    always_comb begin
        hi_req = '0;
        win    = '0;
        found  = |bus.req;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = bus.req[i] && (i > int'(last_q));
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win = LW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) win = LW'(i);
        end
    end

    // Per-frame write budget, restarted when the window opens.
    always_comb begin
        cnt_d = cnt_q;
        if (vblank_d && !vblank_q) begin
            cnt_d = '0;
        end else if (reg_we_q && (cnt_q < CMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Grant sequencer: arbitrate, strobe the bank, then ack the winner.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        last_d     = last_q;
        unique case (state_q)
            S_WAIT: begin
                if (vblank_q && (cnt_q < CMAX)) state_d = S_ARB;
            end
            S_ARB: begin
                if (!vblank_q || (cnt_q >= CMAX)) begin
                    state_d = S_WAIT;
                end else if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    reg_we_d   = 1'b1;
                    reg_addr_d = bus.wr_addr[int'(win)*AW +: AW];
                    reg_data_d = bus.wr_data[int'(win)*DW +: DW];
                    last_d     = win;
                    state_d    = S_WR;
                end
            end
            S_WR: begin
                ack_d   = gnt_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                gnt_d   = '0;
                state_d = vblank_q ? S_ARB : S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // State and output registers; reset aborts any write in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_WAIT;
            gnt_q         <= '0;
            ack_q         <= '0;
            reg_we_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_data_q    <= '0;
            last_q        <= LAST_RST;
            cnt_q         <= '0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
            starved_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            reg_we_q      <= reg_we_d;
            reg_addr_q    <= reg_addr_d;
            reg_data_q    <= reg_data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
            starved_q     <= starved_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign reg_we      = reg_we_q;
    assign reg_addr    = reg_addr_q;
    assign reg_data    = reg_data_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;
    assign starved     = starved_q;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Bench for the vblank write scheduler: queued producers, compressed
// line timing (4 pixels per line) and a rule-level reference model.
module tb_vga_update_scheduler;
    localparam int NREQ   = 4;
    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int VD     = 480;
    localparam int VT     = 525;
    localparam int MAX_WR = 16;
    localparam int HT     = 4;
    localparam int MAXCYC = 40000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b1;
    logic [9:0]    pixelx = '0;
    logic [9:0]    pixely = '0;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic          vblank;
    logic          frame_start;
    logic          starved;

    vga_update_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    vga_update_scheduler #(
        .NREQ(NREQ), .AW(AW), .DW(DW),
        .VD(VD), .VT(VT), .MAX_WR(MAX_WR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .pixelx     (pixelx),
        .pixely     (pixely),
        .bus        (bus),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .vblank     (vblank),
        .frame_start(frame_start),
        .starved    (starved)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] fifo [NREQ][64];
    int hd [NREQ];
    int tl [NREQ];

    int mlast = NREQ - 1;
    int frame_writes = 0;
    int cyc = 0;
    int last_we_cyc = -100;
    int next_at = -1;
    int ack_w = 0;
    int frames = 0;
    int fs_count = 0;
    int post_rst_w = -1;
    bit ack_pend = 0;
    bit last_vb = 0;
    bit prev2_vb = 0;
    bit late_push = 0;
    bit after_rst = 0;
    int first_w [8];
    int wpf [8];
    int st_count [8];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_window(input logic [9:0] y);
        return (int'(y) >= VD) && (int'(y) <= VT - 2);
    endfunction

    function automatic int rr(input int last, input logic [NREQ-1:0] r);
        int res;
        int c;
        res = -1;
        for (int k = NREQ; k >= 1; k--) begin
            c = (last + k) % NREQ;
            if (r[c]) res = c;
        end
        return res;
    endfunction

    task automatic drive_bus();
        logic [NREQ-1:0]    r;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        logic [AW+DW-1:0]   e;
        r = '0;
        a = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (hd[i] != tl[i]) begin
                e = fifo[i][hd[i]];
                r[i] = 1'b1;
                a[i*AW +: AW] = e[AW+DW-1:DW];
                d[i*DW +: DW] = e[DW-1:0];
            end
        end
        bus.req     = r;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic push(input int i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        fifo[i][tl[i]] = {a, d};
        tl[i]++;
        drive_bus();
    endtask

    task automatic push_rand(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            push(i, AW'($urandom), DW'($urandom));
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_ack;
        logic [AW+DW-1:0] e;
        bit rst_e;
        bit exp_vb;
        bit exp_fs;
        bit exp_st;
        int w;
        @(posedge clk);
        #1;
        cyc++;
        r      = bus.req;
        rst_e  = reset;
        exp_vb = rst_e && in_window(pixely);
        exp_fs = rst_e && tick && (pixelx == 0) && (pixely == 0);
        exp_st = rst_e && last_vb && !exp_vb && (r != 0);
        chk("vblank", vblank, exp_vb);
        chk("frame_start", frame_start, exp_fs);
        chk("starved", starved, exp_st);
        if (frame_start) fs_count++;
        if (starved) st_count[frames]++;
        if (!rst_e) begin
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_ack", bus.ack, 0);
            chk("rst_we", reg_we, 0);
            chk("rst_addr", reg_addr, 0);
            chk("rst_data", reg_data, 0);
            mlast = NREQ - 1;
            ack_pend = 0;
            frame_writes = 0;
            next_at = -1;
        end else begin
            if (!last_vb && exp_vb) begin
                frame_writes = 0;
                late_push = 0;
            end
            if (last_vb && !exp_vb) begin
                wpf[frames] = frame_writes;
                if (r != 0 && !late_push) begin
                    chk("budget_used", frame_writes, MAX_WR);
                end
            end
            exp_ack = '0;
            if (ack_pend) exp_ack[ack_w] = 1'b1;
            chk("ack", bus.ack, exp_ack);
            exp_gnt = exp_ack;
            if (cyc == next_at && prev2_vb && last_vb && r != 0 &&
                frame_writes < MAX_WR) begin
                chk("throughput", reg_we, 1);
            end
            ack_pend = 0;
            if (reg_we) begin
                w = rr(mlast, r);
                chk("we_in_window", last_vb, 1);
                chk("we_spacing", (cyc - last_we_cyc) >= 3, 1);
                chk("we_has_req", w >= 0, 1);
                if (w >= 0) begin
                    e = fifo[w][hd[w]];
                    exp_gnt = '0;
                    exp_gnt[w] = 1'b1;
                    chk("addr", reg_addr, e[AW+DW-1:DW]);
                    chk("data", reg_data, e[DW-1:0]);
                    frame_writes++;
                    chk("budget_cap", frame_writes <= MAX_WR, 1);
                    if (first_w[frames] < 0) first_w[frames] = w;
                    if (after_rst) begin
                        post_rst_w = w;
                        after_rst = 0;
                    end
                    mlast = w;
                    ack_pend = 1;
                    ack_w = w;
                end
                next_at = cyc + 3;
                last_we_cyc = cyc;
            end
            chk("gnt", bus.gnt, exp_gnt);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i] && hd[i] != tl[i]) hd[i]++;
        end
        prev2_vb = last_vb;
        last_vb = exp_vb;
        if (tick) begin
            if (int'(pixelx) == HT - 1) begin
                pixelx = '0;
                if (int'(pixely) == VT - 1) begin
                    pixely = '0;
                    frames++;
                end else begin
                    pixely = pixely + 10'd1;
                end
            end else begin
                pixelx = pixelx + 10'd1;
            end
        end
        tick = ~tick;
        drive_bus();
    endtask

    task automatic run_to(input int f, input int y);
        while (!(frames == f && int'(pixely) == y && pixelx == 0) &&
               cyc < MAXCYC) begin
            step();
        end
        if (cyc >= MAXCYC) begin
            n_assert++;
            n_fail++;
            $error("FAIL timeout: observed frame %0d line %0d expected %0d/%0d",
                   frames, pixely, f, y);
        end
    endtask

    initial begin
        int pend;
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            first_w[i] = -1;
            wpf[i] = -1;
            st_count[i] = 0;
        end
        drive_bus();

        repeat (3) step();
        reset = 1'b1;

        run_to(0, 100);
        push(2, 4'h5, 8'hA3);

        run_to(1, 100);
        for (int i = 0; i < NREQ; i++) push_rand(i, 8);

        run_to(3, 100);
        push_rand(3, 1);
        push_rand(0, 8);
        push_rand(1, 9);

        run_to(4, 100);
        push_rand(0, 2);
        push_rand(2, 2);
        while (!(reg_we && frames == 4 && frame_writes == 2) &&
               cyc < MAXCYC) begin
            step();
        end
        if (cyc >= MAXCYC) begin
            n_assert++;
            n_fail++;
            $error("FAIL timeout: observed no second write in frame %0d expected one",
                   frames);
        end
        reset = 1'b0;
        #1;
        chk("async_gnt", bus.gnt, 0);
        chk("async_we", reg_we, 0);
        chk("async_ack", bus.ack, 0);
        step();
        step();
        reset = 1'b1;
        after_rst = 1;

        run_to(5, 523);
        late_push = 1;
        push_rand(3, 1);

        run_to(6, 10);

        chk("f0_first", first_w[0], 2);
        chk("f0_writes", wpf[0], 1);
        chk("f0_starved", st_count[0], 0);
        chk("f1_writes", wpf[1], MAX_WR);
        chk("f1_starved", st_count[1], 1);
        chk("f2_writes", wpf[2], MAX_WR);
        chk("f2_starved", st_count[2], 0);
        chk("f3_writes", wpf[3], MAX_WR);
        chk("f3_starved", st_count[3], 1);
        chk("f4_first", first_w[4], 1);
        chk("post_reset_first", post_rst_w, 0);
        chk("f4_writes", wpf[4], 5);
        chk("f5_first", first_w[5], 3);
        chk("frame_pulses", fs_count, frames);
        pend = 0;
        for (int i = 0; i < NREQ; i++) pend += tl[i] - hd[i];
        chk("drained", pend, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_update_scheduler.md
Name: vga_update_scheduler

Overview:
- Arbitrates write requests from NREQ producers (clock digits, date, alarm, cursor) to the shared display-register bank that the pixel generator reads.
- Grants writes only inside the vertical-blanking window derived from the VGA sync counters, so visible content never changes mid-frame (no tearing).
- Round-robin fairness with a per-frame write budget.
- Sits between the producer logic and the display-register bank. Consumes pixelx/pixely/tick from the sync generator.

Parameters:
- NREQ, 4, number of requesters.
- AW, 4, register-bank address width.
- DW, 8, register-bank data width.
- VD, 480, visible lines; the window opens at line VD.
- VT, 525, total lines; the window closes at line VT-1.
- MAX_WR, 16, maximum writes granted per frame (counter width clog2(MAX_WR+1)).

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous reset, active-low (0 = reset)
- tick  in  1  pixel-rate enable from the sync generator
- pixelx  in  10  current horizontal count
- pixely  in  10  current vertical count
- req  in  NREQ  per-requester write request, level
- wr_addr  in  NREQ*AW  per-requester address; requester i uses slice [i*AW +: AW]
- wr_data  in  NREQ*DW  per-requester data; same slicing as wr_addr
- gnt  out  NREQ  one-hot grant
- ack  out  NREQ  one-cycle completion pulse to the winner
- reg_we  out  1  register-bank write strobe
- reg_addr  out  AW  register-bank address
- reg_data  out  DW  register-bank data
- vblank  out  1  registered update-window flag
- frame_start  out  1  one-cycle pulse at the start of each frame
- starved  out  1  one-cycle pulse when the window closes with any req still high

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; reg_addr and reg_data 0.
  - FSM in S_WAIT; write counter 0; round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset mid-write aborts the write: no ack is issued.
- vblank register: updated every clk with (pixely>=VD && pixely<VT-1). The last line is a guard line so that any write in flight completes before line 0.
- frame_start: registered; 1 for exactly one clk, on the clk after the edge where tick=1, pixelx=0, pixely=0.
- Write counter:
  - Cleared on the vblank rising edge.
  - Incremented on each reg_we.
  - Saturates at MAX_WR.
- FSM states:
  - S_WAIT: no grants. Go to S_ARB when vblank=1 and counter<MAX_WR.
  - S_ARB: if vblank=0 or counter==MAX_WR, go to S_WAIT. Otherwise, if req!=0, pick the winner w = first i with req[i]=1, searching from last+1 upward modulo NREQ. At the next edge register: gnt=onehot(w), reg_we=1, reg_addr/reg_data = slice w, last=w; go to S_ACK. If req==0, stay in S_ARB.
  - S_ACK: reg_we=0, ack[w]=1, gnt held. Next state is S_ARB, or S_WAIT if vblank has dropped. gnt clears on leaving S_ACK.
- Timing: with req sampled in S_ARB at edge N:
  - gnt high in cycles N+1..N+2.
  - reg_we high in N+1 only.
  - ack high in N+2 only.
  - Next arbitration is at edge N+3, so peak throughput is 1 write per 3 clk.
- Requester rules:
  - Addr/data must be stable while req=1; they are sampled only at the grant edge.
  - The requester drops req after ack unless it has another write. A still-high req is treated as a new request and rotates fairly.
- Window closing:
  - If the window closes during S_ACK, the ack still completes.
  - If it closes during S_ARB, no new grant is issued.
  - starved pulses for one clk on the vblank falling edge if req!=0 at that edge.
- Budget exhausted: remaining requests wait for the next frame. starved pulses at window close if any are still pending.
- Requests arriving during active video are held pending (level) and served once the window opens; they are not lost.
- tick is used only for frame_start. Arbitration runs at full clk rate.

Test Plan:
- Reset then release with req=0: all outputs 0. frame_start pulses once per 800*525 ticks. vblank is high for lines 480..523 only.
- req[2]=1, addr=4'h5, data=8'hA3, asserted at line 100 → no gnt until vblank rises. Then reg_we=1 with reg_addr=5, reg_data=A3, gnt=0100. ack[2] follows one clk later.
- req=1111 held inside vblank → grant order 0,1,2,3,0,… Each gnt is one-hot, reg_we is spaced 3 clk apart, and exactly 16 writes occur per frame (MAX_WR=16).
- With MAX_WR=16 reached and req[1] still high → no further reg_we. starved pulses once at the vblank falling edge. req[1] is served first in the next frame if last=0.
- Grant issued at the last cycle before line 524 → ack still pulses, FSM then enters S_WAIT, and no reg_we occurs on line 524 or in active video.
- reset asserted in the cycle where reg_we=1 → gnt, ack and reg_we drop to 0 asynchronously. No ack is seen, and after release requester 0 has priority.
